// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer: FSM states, redirect source codes, PC step.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_BUBBLE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALT   = 3'd4
    } fetch_state_t;

    localparam logic [1:0]  REDIR_SRC_NONE = 2'b00;
    localparam logic [1:0]  REDIR_SRC_DEC  = 2'b01;
    localparam logic [1:0]  REDIR_SRC_EX   = 2'b10;
    localparam logic [1:0]  REDIR_SRC_CMT  = 2'b11;

    localparam logic [31:0] PC_INCR = 32'd4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/redirect_priority_arb.sv
// Combinational 3-way redirect select, commit > execute > decode; zero latency, losers dropped.
module redirect_priority_arb
    import fetch_seq_pkg::*;
(
    input  logic        i_dec_vld,
    input  logic [31:0] i_dec_target,
    input  logic        i_ex_vld,
    input  logic [31:0] i_ex_target,
    input  logic        i_cmt_vld,
    input  logic [31:0] i_cmt_target,
    output logic        o_vld,
    output logic [31:0] o_target,
    output logic [1:0]  o_src
);

    always_comb begin
        o_vld    = 1'b0;
        o_target = 32'd0;
        o_src    = REDIR_SRC_NONE;
        if (i_cmt_vld) begin
            o_vld    = 1'b1;
            o_target = i_cmt_target;
            o_src    = REDIR_SRC_CMT;
        end else if (i_ex_vld) begin
            o_vld    = 1'b1;
            o_target = i_ex_target;
            o_src    = REDIR_SRC_EX;
        end else if (i_dec_vld) begin
            o_vld    = 1'b1;
            o_target = i_dec_target;
            o_src    = REDIR_SRC_DEC;
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: +4 sequencing, prioritized redirects, flush pulses and post-redirect drain.
// One-cycle redirect latency; Fetch_Ready only stalls the PC in RUN. FETCH_ALIGN_CHECK_EN enables HALT on misaligned targets.
module fetch_pc_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'hBFC00000,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Fetch_Ready,
    input  logic        Dec_Redir_Valid,
    input  logic [31:0] Dec_Redir_Target,
    input  logic        Ex_Redir_Valid,
    input  logic [31:0] Ex_Redir_Target,
    input  logic        Cmt_Flush_Valid,
    input  logic [31:0] Cmt_Flush_Target,
    output logic [31:0] PC,
    output logic        PC_Valid,
    output logic        Flush_Fetch,
    output logic        Flush_All,
    output logic [1:0]  Redir_Src,
    output logic [15:0] Redir_Count,
    output logic        Fetch_Misaligned
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [3:0]   r_drain, w_drain_nxt;
    logic         r_flush_fetch, w_flush_fetch_nxt;
    logic         r_flush_all, w_flush_all_nxt;
    logic [1:0]   r_src, w_src_nxt;
    logic [15:0]  r_count, w_count_nxt;

    logic         w_younger_open;
    logic         w_cmt_open;
    logic         w_arb_vld;
    logic [31:0]  w_arb_target;
    logic [1:0]   w_arb_src;
    logic [31:0]  w_target;

    // Decode/execute redirects are squashed by an in-flight commit flush or a halt.
    assign w_younger_open = (r_state == ST_RUN) || (r_state == ST_BUBBLE);
    assign w_cmt_open     = (r_state != ST_IDLE);

    redirect_priority_arb u_arb (
        .i_dec_vld    (Dec_Redir_Valid & w_younger_open),
        .i_dec_target (Dec_Redir_Target),
        .i_ex_vld     (Ex_Redir_Valid & w_younger_open),
        .i_ex_target  (Ex_Redir_Target),
        .i_cmt_vld    (Cmt_Flush_Valid & w_cmt_open),
        .i_cmt_target (Cmt_Flush_Target),
        .o_vld        (w_arb_vld),
        .o_target     (w_arb_target),
        .o_src        (w_arb_src)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misaligned, w_misaligned_nxt;
    logic w_target_mis;
    assign w_target       = w_arb_target;
    assign w_target_mis   = |w_arb_target[1:0];
    assign Fetch_Misaligned = r_misaligned;
`else
    assign w_target       = w_arb_target & ~32'h3;
    assign Fetch_Misaligned = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drain_nxt       = r_drain;
        w_flush_fetch_nxt = 1'b0;
        w_flush_all_nxt   = 1'b0;
        w_src_nxt         = r_src;
        w_count_nxt       = r_count;
`ifdef FETCH_ALIGN_CHECK_EN
        w_misaligned_nxt  = r_misaligned;
`endif
        if (w_arb_vld) begin
            w_pc_nxt    = w_target;
            w_src_nxt   = w_arb_src;
            w_count_nxt = sat_inc16(r_count);
            if (w_arb_src == REDIR_SRC_CMT) begin
                w_flush_all_nxt = 1'b1;
                w_state_nxt     = ST_DRAIN;
                w_drain_nxt     = DRAIN_LOAD;
            end else begin
                w_flush_fetch_nxt = 1'b1;
                w_state_nxt       = ST_BUBBLE;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_target_mis) begin
                w_state_nxt      = ST_HALT;
                w_misaligned_nxt = 1'b1;
            end else if (w_arb_src == REDIR_SRC_CMT) begin
                w_misaligned_nxt = 1'b0;
            end
`endif
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_RUN;
                ST_RUN:    if (Fetch_Ready) w_pc_nxt = r_pc + PC_INCR;
                ST_BUBBLE: w_state_nxt = ST_RUN;
                ST_DRAIN: begin
                    if (r_drain == 4'd0) w_state_nxt = ST_RUN;
                    else                 w_drain_nxt = r_drain - 4'd1;
                end
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_drain       <= 4'd0;
            r_flush_fetch <= 1'b0;
            r_flush_all   <= 1'b0;
            r_src         <= REDIR_SRC_NONE;
            r_count       <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drain       <= w_drain_nxt;
            r_flush_fetch <= w_flush_fetch_nxt;
            r_flush_all   <= w_flush_all_nxt;
            r_src         <= w_src_nxt;
            r_count       <= w_count_nxt;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RESET) r_misaligned <= 1'b0;
        else       r_misaligned <= w_misaligned_nxt;
    end
`endif

    assign PC          = r_pc;
    assign PC_Valid    = (r_state == ST_RUN);
    assign Flush_Fetch = r_flush_fetch;
    assign Flush_All   = r_flush_all;
    assign Redir_Src   = r_src;
    assign Redir_Count = r_count;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed vector bench for fetch_pc_sequencer: one table row per clock, plus a drain-length sequence.
module tb_fetch_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Fetch_Ready = 1'b0;
    logic        Dec_Redir_Valid = 1'b0;
    logic [31:0] Dec_Redir_Target = 32'd0;
    logic        Ex_Redir_Valid = 1'b0;
    logic [31:0] Ex_Redir_Target = 32'd0;
    logic        Cmt_Flush_Valid = 1'b0;
    logic [31:0] Cmt_Flush_Target = 32'd0;
    logic [31:0] PC;
    logic        PC_Valid;
    logic        Flush_Fetch;
    logic        Flush_All;
    logic [1:0]  Redir_Src;
    logic [15:0] Redir_Count;
    logic        Fetch_Misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fetch_pc_sequencer #(
        .RESET_PC     (32'hBFC00000),
        .DRAIN_CYCLES (2)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Fetch_Ready      (Fetch_Ready),
        .Dec_Redir_Valid  (Dec_Redir_Valid),
        .Dec_Redir_Target (Dec_Redir_Target),
        .Ex_Redir_Valid   (Ex_Redir_Valid),
        .Ex_Redir_Target  (Ex_Redir_Target),
        .Cmt_Flush_Valid  (Cmt_Flush_Valid),
        .Cmt_Flush_Target (Cmt_Flush_Target),
        .PC               (PC),
        .PC_Valid         (PC_Valid),
        .Flush_Fetch      (Flush_Fetch),
        .Flush_All        (Flush_All),
        .Redir_Src        (Redir_Src),
        .Redir_Count      (Redir_Count),
        .Fetch_Misaligned (Fetch_Misaligned)
    );

    typedef struct {
        logic        rst;
        logic        fr;
        logic        dv;
        logic [31:0] dt;
        logic        ev;
        logic [31:0] et;
        logic        cv;
        logic [31:0] ct;
        logic [31:0] pc;
        logic        vld;
        logic        ff;
        logic        fa;
        logic [1:0]  src;
        logic [15:0] cnt;
        logic        mis;
    } vec_t;

    localparam int NV = 30;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic rst, input logic fr,
        input logic dv, input logic [31:0] dt,
        input logic ev, input logic [31:0] et,
        input logic cv, input logic [31:0] ct,
        input logic [31:0] pc, input logic vld, input logic ff, input logic fa,
        input logic [1:0] src, input logic [15:0] cnt, input logic mis);
        vec_t v;
        v.rst = rst; v.fr = fr; v.dv = dv; v.dt = dt; v.ev = ev; v.et = et;
        v.cv = cv; v.ct = ct; v.pc = pc; v.vld = vld; v.ff = ff; v.fa = fa;
        v.src = src; v.cnt = cnt; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //            rst fr  dv  dt            ev  et            cv  ct            pc            vld ff  fa  src    cnt     mis
        tv[0]  = mk('1, '0, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'hBFC00000, '0, '0, '0, 2'b00, 16'd0, '0);
        tv[1]  = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'hBFC00000, '1, '0, '0, 2'b00, 16'd0, '0);
        tv[2]  = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'hBFC00004, '1, '0, '0, 2'b00, 16'd0, '0);
        tv[3]  = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'hBFC00008, '1, '0, '0, 2'b00, 16'd0, '0);
        tv[4]  = mk('0, '0, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'hBFC00008, '1, '0, '0, 2'b00, 16'd0, '0);
        tv[5]  = mk('0, '1, '1, 32'h00400100, '0, 32'h0,        '0, 32'h0,        32'h00400100, '0, '1, '0, 2'b01, 16'd1, '0);
        tv[6]  = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00400100, '1, '0, '0, 2'b01, 16'd1, '0);
        tv[7]  = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00400104, '1, '0, '0, 2'b01, 16'd1, '0);
        tv[8]  = mk('0, '1, '1, 32'h00000100, '1, 32'h00000200, '1, 32'h80000180, 32'h80000180, '0, '0, '1, 2'b11, 16'd2, '0);
        tv[9]  = mk('0, '1, '0, 32'h0,        '1, 32'h00000300, '0, 32'h0,        32'h80000180, '0, '0, '0, 2'b11, 16'd2, '0);
        tv[10] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h80000180, '1, '0, '0, 2'b11, 16'd2, '0);
        tv[11] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h80000184, '1, '0, '0, 2'b11, 16'd2, '0);
        tv[12] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '1, 32'h80000200, 32'h80000200, '0, '0, '1, 2'b11, 16'd3, '0);
        tv[13] = mk('0, '0, '0, 32'h0,        '0, 32'h0,        '1, 32'h80000300, 32'h80000300, '0, '0, '1, 2'b11, 16'd4, '0);
        tv[14] = mk('0, '0, '1, 32'h00000500, '0, 32'h0,        '0, 32'h0,        32'h80000300, '0, '0, '0, 2'b11, 16'd4, '0);
        tv[15] = mk('0, '0, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h80000300, '1, '0, '0, 2'b11, 16'd4, '0);
        tv[16] = mk('0, '0, '0, 32'h0,        '1, 32'h00001000, '0, 32'h0,        32'h00001000, '0, '1, '0, 2'b10, 16'd5, '0);
        tv[17] = mk('0, '1, '1, 32'h00002000, '0, 32'h0,        '0, 32'h0,        32'h00002000, '0, '1, '0, 2'b01, 16'd6, '0);
        tv[18] = mk('0, '1, '0, 32'h0,        '1, 32'hFFFFFFF8, '0, 32'h0,        32'hFFFFFFF8, '0, '1, '0, 2'b10, 16'd7, '0);
        tv[19] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'hFFFFFFF8, '1, '0, '0, 2'b10, 16'd7, '0);
        tv[20] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'hFFFFFFFC, '1, '0, '0, 2'b10, 16'd7, '0);
        tv[21] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00000000, '1, '0, '0, 2'b10, 16'd7, '0);
        tv[22] = mk('0, '0, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00000000, '1, '0, '0, 2'b10, 16'd7, '0);
`ifdef FETCH_ALIGN_CHECK_EN
        tv[23] = mk('0, '0, '1, 32'h00400102, '0, 32'h0,        '0, 32'h0,        32'h00400102, '0, '1, '0, 2'b01, 16'd8, '1);
        tv[24] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00400102, '0, '0, '0, 2'b01, 16'd8, '1);
`else
        tv[23] = mk('0, '0, '1, 32'h00400102, '0, 32'h0,        '0, 32'h0,        32'h00400100, '0, '1, '0, 2'b01, 16'd8, '0);
        tv[24] = mk('0, '1, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00400100, '1, '0, '0, 2'b01, 16'd8, '0);
`endif
        tv[25] = mk('0, '0, '0, 32'h0,        '0, 32'h0,        '1, 32'h00400200, 32'h00400200, '0, '0, '1, 2'b11, 16'd9, '0);
        tv[26] = mk('0, '0, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00400200, '0, '0, '0, 2'b11, 16'd9, '0);
        tv[27] = mk('0, '0, '0, 32'h0,        '0, 32'h0,        '0, 32'h0,        32'h00400200, '1, '0, '0, 2'b11, 16'd9, '0);
        tv[28] = mk('1, '1, '1, 32'h00000100, '0, 32'h0,        '0, 32'h0,        32'hBFC00000, '0, '0, '0, 2'b00, 16'd0, '0);
        tv[29] = mk('0, '0, '1, 32'h00000100, '0, 32'h0,        '1, 32'h00000200, 32'hBFC00000, '1, '0, '0, 2'b00, 16'd0, '0);

        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            RESET            = tv[i].rst;
            Fetch_Ready      = tv[i].fr;
            Dec_Redir_Valid  = tv[i].dv;
            Dec_Redir_Target = tv[i].dt;
            Ex_Redir_Valid   = tv[i].ev;
            Ex_Redir_Target  = tv[i].et;
            Cmt_Flush_Valid  = tv[i].cv;
            Cmt_Flush_Target = tv[i].ct;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d.pc", i),    PC,                       tv[i].pc);
            chk($sformatf("v%0d.vld", i),   {31'd0, PC_Valid},        {31'd0, tv[i].vld});
            chk($sformatf("v%0d.ff", i),    {31'd0, Flush_Fetch},     {31'd0, tv[i].ff});
            chk($sformatf("v%0d.fa", i),    {31'd0, Flush_All},       {31'd0, tv[i].fa});
            chk($sformatf("v%0d.src", i),   {30'd0, Redir_Src},       {30'd0, tv[i].src});
            chk($sformatf("v%0d.cnt", i),   {16'd0, Redir_Count},     {16'd0, tv[i].cnt});
            chk($sformatf("v%0d.mis", i),   {31'd0, Fetch_Misaligned}, {31'd0, tv[i].mis});
        end

        // Commit flush from RUN: PC_Valid must stay low for exactly two cycles.
        @(negedge CLK);
        Dec_Redir_Valid  = 1'b0;
        Fetch_Ready      = 1'b1;
        Cmt_Flush_Valid  = 1'b1;
        Cmt_Flush_Target = 32'h00001000;
        @(posedge CLK);
        #1;
        Cmt_Flush_Valid  = 1'b0;
        begin
            int  lows;
            bit  seen;
            lows = 0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                if (PC_Valid) seen = 1'b1;
                else begin
                    lows++;
                    @(posedge CLK);
                    #1;
                end
            end
            if (!seen) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: PC_Valid still low after 20 cycles, expected high after 2");
            end else begin
                chk("drain_len", 32'(lows), 32'd2);
            end
            chk("drain_pc",  PC, 32'h00001000);
            chk("drain_cnt", {16'd0, Redir_Count}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
